// File: rtl/alu_op_ctrl.sv
// alu_op_ctrl: one-at-a-time sequencer for the 8-bit ALU (AND/OR/ADD in one cycle, MUL by shift-add).
// Define ALU_OP_CTRL_FAST_MUL_EN to replace the shift-add MUL with a single-cycle combinational product.
module alu_op_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic             out_carry,
  output logic [1:0]       out_opcode,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_MUL = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
`ifndef ALU_OP_CTRL_FAST_MUL_EN
    , S_MUL = 2'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  opcode_t           op_q, op_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        b_q, b_d;
  logic [15:0]       result_q, result_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  count_q, count_d;

`ifndef ALU_OP_CTRL_FAST_MUL_EN
  logic [15:0]       acc_q, acc_d;
  logic [2:0]        bit_q, bit_d;
  logic [15:0]       partial;
  logic [15:0]       acc_sum;
`endif

  // Returns {carry, formatted_result}; logical results sign-extend bit 7 like the ALU output mux.
  function automatic logic [16:0] alu_format(input opcode_t op, input logic [7:0] a,
                                             input logic [7:0] b);
    logic [7:0] r;
    logic [8:0] sum;
    r          = '0;
    sum        = {1'b0, a} + {1'b0, b};
    alu_format = '0;
    case (op)
      OP_AND: begin
        r          = a & b;
        alu_format = {1'b0, {8{r[7]}}, r};
      end
      OP_OR: begin
        r          = a | b;
        alu_format = {1'b0, {8{r[7]}}, r};
      end
      OP_ADD: alu_format = {sum[8], {8{sum[7]}}, sum[7:0]};
      OP_MUL: begin
`ifdef ALU_OP_CTRL_FAST_MUL_EN
        alu_format = {1'b0, {8'b0, a} * {8'b0, b}};
`endif
      end
      default: alu_format = '0;
    endcase
  endfunction

  assign in_ready   = (state_q == S_IDLE) && !rst;
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_result = result_q;
  assign out_carry  = carry_q;
  assign out_opcode = op_q;
  assign op_count   = count_q;

`ifndef ALU_OP_CTRL_FAST_MUL_EN
  // LSB-first shift-add: the product bit in play this cycle is b[bit_q].
  assign partial = b_q[bit_q] ? ({8'b0, a_q} << bit_q) : 16'd0;
  assign acc_sum = acc_q + partial;
`endif

  always_comb begin
    // NOTE: every signal assigned below gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    count_d  = count_q;
`ifndef ALU_OP_CTRL_FAST_MUL_EN
    acc_d    = acc_q;
    bit_d    = bit_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          op_d    = opcode_t'(in_opcode);
          a_d     = in_a;
          b_d     = in_b;
          state_d = S_EXEC;
`ifndef ALU_OP_CTRL_FAST_MUL_EN
          if (opcode_t'(in_opcode) == OP_MUL) begin
            acc_d   = '0;
            bit_d   = '0;
            state_d = S_MUL;
          end
`endif
        end
      end

      S_EXEC: begin
        {carry_d, result_d} = alu_format(op_q, a_q, b_q);
        state_d             = S_DONE;
      end

`ifndef ALU_OP_CTRL_FAST_MUL_EN
      S_MUL: begin
        acc_d = acc_sum;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          result_d = acc_sum;
          carry_d  = 1'b0;
          state_d  = S_DONE;
        end
      end
`endif

      S_DONE: begin
        if (out_ready) begin
          count_d = count_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
`ifndef ALU_OP_CTRL_FAST_MUL_EN
      acc_q    <= '0;
      bit_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
`ifndef ALU_OP_CTRL_FAST_MUL_EN
      acc_q    <= acc_d;
      bit_q    <= bit_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Scoreboard bench for alu_op_ctrl: the driver queues hand-computed results, a monitor pops them on each
// response handshake. Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_alu_op_ctrl;

  localparam int CNT_W   = 4;
  localparam int ALU_LAT = 2;
`ifdef ALU_OP_CTRL_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 9;
`endif

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_opcode;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_result;
  logic             out_carry;
  logic [1:0]       out_opcode;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  typedef struct {
    logic [15:0] res;
    logic        carry;
    logic [1:0]  op;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_count = '0;

  alu_op_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_opcode (out_opcode),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a response handshake completes on the rising edge after this sample.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got 0x%0h, want no response", out_result);
        end else begin
          e = sb.pop_front();
          check("sb_result", out_result, e.res);
          check("sb_carry", out_carry, e.carry);
          check("sb_opcode", out_opcode, e.op);
        end
      end
    end
  end

  // Issue one request from IDLE, check latency, optionally hold out_ready low, then check the return to IDLE.
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] res, input logic carry, input int lat,
                        input int hold, input string tag);
    int   n;
    int   busy_low;
    exp_t e;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    out_ready = (hold == 0);
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    e.res   = res;
    e.carry = carry;
    e.op    = op;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_opcode = ~op;
    in_a      = ~a;
    in_b      = ~b;
    n         = 0;
    busy_low  = 0;
    do begin
      @(negedge clk);
      n++;
      if (!busy) busy_low++;
    end while (!out_valid && n < 30);
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_low_cycles"}, busy_low, 0);
    if (!out_valid) return;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_opcode = OP_AND;
      in_a      = 8'hA5;
      in_b      = 8'h5A;
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_result"}, out_result, res);
      check({tag, "_hold_in_ready"}, in_ready, 1'b0);
      in_valid = 1'b0;
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    exp_count++;
    check({tag, "_idle_valid"}, out_valid, 1'b0);
    check({tag, "_idle_in_ready"}, in_ready, 1'b1);
    check({tag, "_op_count"}, op_count, exp_count);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = 2'b00;
    in_a      = 8'h00;
    in_b      = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_op_count", op_count, 4'd0);
    check("rst_result", out_result, 16'h0000);
    check("rst_carry", out_carry, 1'b0);
    check("rst_opcode", out_opcode, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);

    run_op(OP_AND, 8'hF0, 8'h8F, 16'hFF80, 1'b0, ALU_LAT, 0, "and");
    run_op(OP_OR,  8'h01, 8'h02, 16'h0003, 1'b0, ALU_LAT, 0, "or");
    run_op(OP_ADD, 8'h7F, 8'h01, 16'hFF80, 1'b0, ALU_LAT, 0, "add_ovf");
    run_op(OP_ADD, 8'hFF, 8'h01, 16'h0000, 1'b1, ALU_LAT, 0, "add_carry");
    run_op(OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, MUL_LAT, 0, "mul_ff");
    run_op(OP_MUL, 8'h0C, 8'h0A, 16'h0078, 1'b0, MUL_LAT, 0, "mul_0c");
    run_op(OP_ADD, 8'h12, 8'h34, 16'h0046, 1'b0, ALU_LAT, 5, "add_bp");

    // Reset while a MUL is in progress; the queued result must never appear.
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_opcode = OP_MUL;
    in_a      = 8'hFF;
    in_b      = 8'hFF;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midmul_busy", busy, 1'b1);
    check("midmul_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_count = '0;
    @(negedge clk);
    check("midmul_out_valid", out_valid, 1'b0);
    check("midmul_busy_after", busy, 1'b0);
    check("midmul_op_count", op_count, 4'd0);
    check("midmul_in_ready", in_ready, 1'b1);

    run_op(OP_AND, 8'h3C, 8'h0F, 16'h000C, 1'b0, ALU_LAT, 0, "after_rst");

    for (int i = 1; i <= 15; i++) begin
      run_op(OP_OR, 8'(i), 8'h80, {8'hFF, 8'h80 | 8'(i)}, 1'b0, ALU_LAT, 0, "wrap");
    end
    check("wrap_op_count_zero", op_count, 4'd0);
    check("sb_drained", sb.size(), 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
